// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the mode 0 master and slave blocks.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_rx_state_t;

  localparam int SPI_DATA_W = 8;

endpackage : spi_pkg

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with an optional
// registered rising-edge detect on the synchronized level.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0,
  parameter bit   RISE_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   delayed;
  logic                   rise_q;

  // Shift the pin through the synchronizer chain and register the edge detect.
  // NOTE: non-blocking assignments let every flop sample the previous value of
  // its neighbour, which is what makes this a chain rather than one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages  <= {SYNC_STAGES{RESET_VAL}};
      delayed <= RESET_VAL;
      rise_q  <= 1'b0;
    end else begin
      stages  <= {stages[SYNC_STAGES-2:0], pin};
      delayed <= stages[SYNC_STAGES-1];
      rise_q  <= RISE_EN ? (stages[SYNC_STAGES-1] & ~delayed) : 1'b0;
    end
  end

  assign sync = stages[SYNC_STAGES-1];
  assign rise = rise_q;

endmodule : spi_pin_sync

// File: rtl/spi_mode0_slave_rx.sv
// SPI mode 0 slave receiver: oversampled pins, MSB-first shift on SCLK rising
// edges, one-entry valid/ready holding register, framing and overrun flags.
module spi_mode0_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              di,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic              sclk_s;
  logic              sclk_rise;
  logic              cs_s;
  logic              cs_rise;
  logic              di_s;
  logic              di_rise;
  spi_rx_state_t     state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] next_word;
  logic              unused_ok;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .RISE_EN(1'b1)) u_sclk_sync (
    .clk (clk),
    .rst (rst),
    .pin (sclk),
    .sync(sclk_s),
    .rise(sclk_rise)
  );

  // Chip select idles high, so its chain resets high to avoid a false frame start.
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .RISE_EN(1'b0)) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .pin (cs),
    .sync(cs_s),
    .rise(cs_rise)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .RISE_EN(1'b0)) u_di_sync (
    .clk (clk),
    .rst (rst),
    .pin (di),
    .sync(di_s),
    .rise(di_rise)
  );

  // The shift MSB is never read: a completed word is taken from next_word.
  assign unused_ok = ^{sclk_s, cs_rise, di_rise, shift[DATA_W-1]};

  assign next_word = {shift[DATA_W-2:0], di_s};
  assign busy      = (state == SHIFT);

  // Framing FSM, shift register and output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!cs_s) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            // Deselect wins over a coincident rise; a partial word is dropped.
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            if (bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            shift <= next_word;
            if (bit_cnt == LAST_BIT) begin
              // A concurrent accept frees the register, so only an unaccepted word overruns.
              rx_data  <= next_word;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : spi_mode0_slave_rx

// File: tb/tb_spi_mode0_slave_rx.sv
// Self-checking bench for spi_mode0_slave_rx: directed scenarios plus random
// framed bursts, compared against a word-level model of the holding register.
module tb_spi_mode0_slave_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       di = 1'b0;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words still waiting to be accepted, and the sticky overrun.
  logic [7:0] exp_q[$];
  logic       model_overrun = 1'b0;

  // Monitor counters.
  int n_accept    = 0;
  int n_fe        = 0;
  int n_busy_drop = 0;
  int n_idle_bad  = 0;
  bit track_busy  = 1'b0;
  bit track_idle  = 1'b0;

  spi_mode0_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs       (cs),
    .di       (di),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A finished word lands in the holding register; an unaccepted one is lost.
  task automatic model_push(input logic [7:0] w);
    if (exp_q.size() != 0) begin
      model_overrun = 1'b1;
      void'(exp_q.pop_back());
    end
    exp_q.push_back(w);
  endtask

  task automatic frame_begin(input int half);
    cs = 1'b0;
    tick(half);
  endtask

  task automatic frame_end(input int half);
    cs = 1'b1;
    di = 1'b0;
    tick(half);
  endtask

  // Mode 0: data set while SCLK is low, sampled by the slave on the rising edge.
  task automatic send_bits(input logic [7:0] w, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      di = w[7-i];
      tick(half);
      sclk = 1'b1;
      if (i == 7) model_push(w);
      tick(half);
      sclk = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    check(tag, 32'(exp_q.size()), 32'd0);
    tick(2);
  endtask

  // Handshake and flag monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        n_accept++;
        check("accept_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (frame_err) n_fe++;
      if (track_busy && !busy) n_busy_drop++;
      if (track_idle && (busy || rx_valid || frame_err)) n_idle_bad++;
    end
  end

  initial begin
    int acc0;
    int fe0;
    int half;
    int nwords;
    int sent;

    tick(3);
    rst = 1'b0;
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick(4);

    // Single word at clk/8.
    acc0 = n_accept; fe0 = n_fe;
    frame_begin(4);
    send_bits(8'b1011_0001, 8, 4);
    frame_end(4);
    wait_drain("single_drain");
    check("single_accepts", 32'(n_accept - acc0), 32'd1);
    check("single_overrun", 32'(overrun), 32'(model_overrun));
    check("single_fe", 32'(n_fe - fe0), 32'd0);

    // Back-to-back words inside one frame.
    acc0 = n_accept; n_busy_drop = 0;
    frame_begin(4);
    track_busy = 1'b1;
    send_bits(8'hA5, 8, 4);
    send_bits(8'h3C, 8, 4);
    tick(6);
    track_busy = 1'b0;
    frame_end(4);
    wait_drain("b2b_drain");
    check("b2b_accepts", 32'(n_accept - acc0), 32'd2);
    check("b2b_busy_drops", 32'(n_busy_drop), 32'd0);

    // Backpressure: two words complete with nobody accepting.
    rx_ready = 1'b0;
    frame_begin(4);
    send_bits(8'h11, 8, 4);
    send_bits(8'h22, 8, 4);
    frame_end(4);
    tick(8);
    check("bp_rx_data", 32'(rx_data), 32'(exp_q[0]));
    check("bp_rx_valid", 32'(rx_valid), 32'd1);
    check("bp_overrun", 32'(overrun), 32'(model_overrun));
    rx_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_valid_cleared", 32'(rx_valid), 32'd0);
    check("bp_overrun_sticky", 32'(overrun), 32'(model_overrun));

    // Abort after five bits, then a clean word.
    fe0 = n_fe; acc0 = n_accept;
    frame_begin(4);
    send_bits(8'hE7, 5, 4);
    frame_end(4);
    tick(6);
    check("abort_fe_cycles", 32'(n_fe - fe0), 32'd1);
    check("abort_rx_valid", 32'(rx_valid), 32'd0);
    check("abort_accepts", 32'(n_accept - acc0), 32'd0);
    frame_begin(4);
    send_bits(8'h0F, 8, 4);
    frame_end(4);
    wait_drain("abort_drain");
    check("abort_overrun", 32'(overrun), 32'(model_overrun));

    // Reset in the middle of a word.
    fe0 = n_fe;
    frame_begin(4);
    send_bits(8'h5A, 3, 4);
    rst = 1'b1;
    exp_q.delete();
    model_overrun = 1'b0;
    tick(1);
    rst = 1'b0;
    frame_end(4);
    tick(4);
    check("rstmid_overrun", 32'(overrun), 32'(model_overrun));
    check("rstmid_rx_valid", 32'(rx_valid), 32'd0);
    frame_begin(4);
    send_bits(8'hC3, 8, 4);
    frame_end(4);
    wait_drain("rstmid_drain");
    check("rstmid_fe", 32'(n_fe - fe0), 32'd0);

    // SCLK noise while deselected.
    n_idle_bad = 0; acc0 = n_accept;
    track_idle = 1'b1;
    repeat (10) begin
      di = 1'($urandom);
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(6);
    track_idle = 1'b0;
    check("idle_noise_bad", 32'(n_idle_bad), 32'd0);
    check("idle_noise_accepts", 32'(n_accept - acc0), 32'd0);
    frame_begin(4);
    send_bits(8'h81, 8, 4);
    frame_end(4);
    wait_drain("idle_drain");

    // Random bursts of random words at varying SCLK rates.
    acc0 = n_accept; fe0 = n_fe; sent = 0;
    for (int f = 0; f < 6; f++) begin
      half   = int'($urandom_range(4, 6));
      nwords = int'($urandom_range(1, 3));
      frame_begin(half);
      for (int k = 0; k < nwords; k++) begin
        send_bits(8'($urandom), 8, half);
        sent++;
      end
      frame_end(half);
      wait_drain("rand_drain");
      tick(int'($urandom_range(0, 5)));
    end
    check("rand_accepts", 32'(n_accept - acc0), 32'(sent));
    check("rand_fe", 32'(n_fe - fe0), 32'd0);
    check("rand_overrun", 32'(overrun), 32'(model_overrun));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_spi_mode0_slave_rx

// File: doc/spi_mode0_slave_rx.md
Name: spi_mode0_slave_rx

Overview:
SPI mode 0 (CPOL=0, CPHA=0) slave-side receiver, the far end of the team's SPI mode 0 master transmitter. It oversamples the SCLK, CS and DI pins with its own system clock and samples DI on SCLK rising edges, MSB first. Each completed word is delivered on a valid/ready interface backed by a one-entry holding register. Framing and overrun errors are flagged.

Parameters:
DATA_W, 8, bits per word; must be at least 2.
SYNC_STAGES, 2, synchronizer flops per pin input; must be at least 2.

Ports:
clk  input  1  system clock; must run at least 4x the SCLK frequency.
rst  input  1  synchronous, active-high reset.
sclk  input  1  SPI serial clock from the master (asynchronous to clk).
cs  input  1  chip select, active low (asynchronous).
di  input  1  serial data from the master (asynchronous).
rx_data  output  DATA_W  received word, MSB = first bit received.
rx_valid  output  1  rx_data holds an unconsumed word.
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready.
overrun  output  1  sticky; a word completed while the holding register was full.
frame_err  output  1  one-cycle pulse; cs rose with a partial word in progress.
busy  output  1  high while in SHIFT.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0. Also state=IDLE, bit_cnt=0, shift=0, and all synchronizer and edge flops = 0 (cs sync = 1).
- Input path: sclk, cs and di each pass through SYNC_STAGES flops.
  - rise = sclk_s && !sclk_d, where sclk_d is sclk_s delayed one clk.
  - Falling SCLK edges are ignored; mode 0 only.
- State machine (states IDLE, SHIFT):
  - IDLE: bit_cnt=0. Go to SHIFT when cs_s=0.
  - SHIFT, on rise: shift <= {shift[DATA_W-2:0], di_s}; bit_cnt++.
  - SHIFT, on rise with bit_cnt==DATA_W-1: the word is complete.
    - Load rx_data with the complete word and set rx_valid=1 on that same edge.
    - bit_cnt returns to 0 and the FSM stays in SHIFT, so back-to-back words work while cs stays low.
  - SHIFT, cs_s=1: go to IDLE; clear bit_cnt and shift.
    - If bit_cnt!=0, pulse frame_err for exactly one cycle; the partial word is discarded.
    - A rise coincident with cs_s=1 is ignored.
- Latency: rx_valid is visible SYNC_STAGES+2 clk edges after the final SCLK rising edge at the pin (SYNC_STAGES=2 gives 4 edges).
- Handshake and holding register:
  - rx_valid && rx_ready clears rx_valid on the next edge.
  - rx_data stays stable while rx_valid=1 and no word completes.
  - Word completes while rx_valid=1 and rx_ready=0: the new word overwrites rx_data, rx_valid stays 1, overrun sets.
  - Word completes on the same edge as an accept: not an overrun. The new word loads and rx_valid stays 1.
  - overrun clears only on rst.
- SCLK activity while cs_s=1 has no effect, including on bit_cnt.
- rst mid-word: all state returns to reset values on the next edge. The partial word is lost and no frame_err is raised.
- busy = (state==SHIFT).

Decomposition:
- Shared package spi_pkg:
  - typedef enum logic {IDLE, SHIFT} spi_rx_state_t;
  - localparam SPI_DATA_W = 8 (default for DATA_W).
  - Shared with the master.
- Sub-module spi_pin_sync: parameterised SYNC_STAGES synchronizer plus rise detect. Instantiate one for sclk with rise enabled, and plain syncs for cs and di.

Test Plan:
- Single word: cs low, shift 8'b10110001 MSB first at clk/8 SCLK, rx_ready=1 -> one rx_valid pulse; rx_data=8'hB1; overrun=0; frame_err=0.
- Back-to-back: cs held low for 8'hA5 then 8'h3C, rx_ready=1 -> two handshakes, 8'hA5 then 8'h3C, busy high throughout.
- Backpressure: rx_ready=0 while 8'h11 and then 8'h22 complete -> rx_data=8'h22, rx_valid=1, overrun=1. After rx_ready=1, rx_valid=0 and overrun stays 1.
- Abort: cs rises after 5 rising edges -> frame_err high exactly 1 cycle, rx_valid stays 0. A following full word 8'h0F is received correctly.
- Reset mid-word: rst for 1 cycle after 3 bits, then a full word 8'hC3 -> rx_data=8'hC3, no frame_err.
- Idle noise: SCLK toggles 10 times with cs=1 -> rx_valid, busy and frame_err stay 0. The next framed 8'h81 is received correctly.
